// File: rtl/lane_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : lane_gearbox
// Description : Per-lane width converter with a 2-entry word FIFO that emits
//               LSB-first OUT_WIDTH slices under ready/valid backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_gearbox #(
    parameter int LANE_WIDTH = 1360,
    parameter int OUT_WIDTH  = 136
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [LANE_WIDTH-1:0] i_lane,
    input  logic                  i_sync,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_sync,
    input  logic                  i_ready,
    output logic                  o_overflow
);

    localparam int RATIO = LANE_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((LANE_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
            $error("lane_gearbox: LANE_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    logic [LANE_WIDTH-1:0] r_mem_lane [2];
    logic                  r_mem_sync [2];
    logic [1:0]            r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_overflow;

    logic                  w_ready;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop_slice;
    logic                  w_pop_word;
    logic [LANE_WIDTH-1:0] w_head_lane;

    // No pop-through: a full FIFO refuses input even on its final-slice cycle.
    assign w_ready     = !rst && (r_count < 2'd2);
    assign w_valid     = (r_count != 2'd0);
    assign w_push      = i_valid && w_ready;
    assign w_pop_slice = w_valid && i_ready;
    assign w_pop_word  = w_pop_slice && (r_idx == C_LAST_IDX);
    assign w_head_lane = r_mem_lane[r_rd_ptr];

    assign o_ready    = w_ready;
    assign o_valid    = w_valid;
    assign o_data     = w_valid ? w_head_lane[32'(r_idx) * OUT_WIDTH +: OUT_WIDTH] : '0;
    assign o_sync     = w_valid && r_mem_sync[r_rd_ptr] && (r_idx == '0);
    assign o_overflow = r_overflow;

    // Payload storage is deliberately not reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_lane[r_wr_ptr] <= i_lane;
            r_mem_sync[r_wr_ptr] <= i_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_word) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_pop_slice) begin
                r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            case ({w_push, w_pop_word})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (i_valid && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
